// File: rtl/sha256_pkg.sv
// sha256_pkg -- shared widths, padding constants and FSM encodings for the SHA-256 message feeder.
// Rev 1.0
`default_nettype none
package sha256_pkg;

  localparam int SHA256_BLOCK_W = 512;
  localparam int WORD_W         = 32;

  localparam logic [WORD_W-1:0] PAD_WORD    = 32'h8000_0000;
  localparam logic [3:0]        LEN_WORD_HI = 4'd14;
  localparam logic [3:0]        LEN_WORD_LO = 4'd15;

  typedef enum logic [1:0] {
    F_DATA = 2'd0,
    F_PAD  = 2'd1,
    F_LEN  = 2'd2,
    F_WAIT = 2'd3
  } fill_state_t;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_INIT = 2'd1,
    C_RUN  = 2'd2
  } core_state_t;

endpackage
`default_nettype wire

// File: rtl/sha256_pad_word.sv
// sha256_pad_word -- masks the unused bytes of a final message word and inserts the 0x80 pad byte.
// Rev 1.0
`default_nettype none
module sha256_pad_word
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] data,
  input  logic [2:0]        nbytes,
  output logic [WORD_W-1:0] word
);

  // A full final word (nbytes of 4, or any out-of-range count) passes through;
  // its 0x80 goes into the following word.
  always_comb begin
    word = data;
    case (nbytes)
      3'd1:    word = {data[31:24], PAD_WORD[31:8]};
      3'd2:    word = {data[31:16], PAD_WORD[31:16]};
      3'd3:    word = {data[31:8],  PAD_WORD[31:24]};
      default: word = data;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sha256_msg_feeder.sv
// sha256_msg_feeder -- pads a 32-bit big-endian message stream into 512-bit SHA-256 blocks
// and feeds them to the core through two ping-pong block buffers. Rev 1.0
`default_nettype none
module sha256_msg_feeder
  import sha256_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [WORD_W-1:0]         in_data,
  input  logic                      in_last,
  input  logic [2:0]                in_bytes,
  output logic                      core_start,
  output logic [SHA256_BLOCK_W-1:0] core_block,
  output logic                      core_last_block,
  input  logic                      core_digest_update,
  input  logic                      core_done,
  output logic                      busy,
  output logic                      underrun
);

  localparam int WORDS = SHA256_BLOCK_W / WORD_W;

  logic [WORD_W-1:0] buf_word [2][WORDS];
  logic [1:0]        buf_full;
  logic [1:0]        buf_last;
  logic              wr_sel;
  logic              rd_sel;
  logic [3:0]        wr_idx;
  logic [LEN_W-1:0]  bit_len;
  logic              pad_pend;
  logic              wait_to_pad;
  logic              cur_last;
  fill_state_t       fill_q, fill_d;
  core_state_t       core_q, core_d;

  logic [3:0]        wr_idx_d;
  logic [LEN_W-1:0]  bit_len_d;
  logic              pad_pend_d;
  logic              wait_to_pad_d;
  logic              wr_sel_d;
  logic              word_we;
  logic              len_we;
  logic              set_full;
  logic              set_last;
  logic [WORD_W-1:0] word_wd;
  logic [WORD_W-1:0] last_word;
  logic [63:0]       len64;
  logic              full_word;
  logic              take_blk;
  logic              underrun_set;

  sha256_pad_word u_pad (
    .data   (in_data),
    .nbytes (in_bytes),
    .word   (last_word)
  );

  assign full_word = (in_bytes == 3'd0) || (in_bytes >= 3'd4);
  assign len64     = 64'(bit_len);

  // Fill side: every write of index 15 closes the block and moves to the other buffer.
  always_comb begin
    fill_d        = fill_q;
    wr_idx_d      = wr_idx;
    bit_len_d     = bit_len;
    pad_pend_d    = pad_pend;
    wait_to_pad_d = wait_to_pad;
    wr_sel_d      = wr_sel;
    in_ready      = 1'b0;
    word_we       = 1'b0;
    word_wd       = '0;
    len_we        = 1'b0;
    set_full      = 1'b0;
    set_last      = 1'b0;
    case (fill_q)
      F_DATA: begin
        in_ready = !buf_full[wr_sel];
        if (in_valid && in_ready) begin
          word_we = 1'b1;
          if (!in_last) begin
            word_wd   = in_data;
            bit_len_d = bit_len + LEN_W'(WORD_W);
          end else begin
            word_wd    = last_word;
            pad_pend_d = full_word;
            bit_len_d  = bit_len + (full_word ? LEN_W'(WORD_W) : LEN_W'({in_bytes, 3'b000}));
            fill_d     = F_PAD;
          end
        end
      end
      F_PAD: begin
        if (!pad_pend && wr_idx == LEN_WORD_HI) begin
          fill_d = F_LEN;
        end else begin
          word_we    = 1'b1;
          word_wd    = pad_pend ? PAD_WORD : '0;
          pad_pend_d = 1'b0;
        end
      end
      F_LEN: begin
        len_we        = 1'b1;
        set_full      = 1'b1;
        set_last      = 1'b1;
        bit_len_d     = '0;
        wr_idx_d      = '0;
        wr_sel_d      = ~wr_sel;
        wait_to_pad_d = 1'b0;
        fill_d        = buf_full[~wr_sel] ? F_WAIT : F_DATA;
      end
      F_WAIT: begin
        if (!buf_full[wr_sel]) fill_d = wait_to_pad ? F_PAD : F_DATA;
      end
      default: fill_d = F_DATA;
    endcase

    if (word_we) begin
      wr_idx_d = wr_idx + 4'd1;
      if (wr_idx == LEN_WORD_LO) begin
        set_full = 1'b1;
        wr_sel_d = ~wr_sel;
        if (buf_full[~wr_sel]) begin
          wait_to_pad_d = (fill_d == F_PAD);
          fill_d        = F_WAIT;
        end
      end
    end
  end

  // Core side: the core samples core_block one cycle after core_start and in each digest_update cycle.
  always_comb begin
    core_d       = core_q;
    core_start   = 1'b0;
    take_blk     = 1'b0;
    underrun_set = 1'b0;
    case (core_q)
      C_IDLE: begin
        if (buf_full[rd_sel]) begin
          core_start = 1'b1;
          core_d     = C_INIT;
        end
      end
      C_INIT: begin
        take_blk = 1'b1;
        core_d   = C_RUN;
      end
      C_RUN: begin
        if (core_digest_update && !cur_last) begin
          take_blk     = 1'b1;
          underrun_set = !buf_full[rd_sel];
        end else if (cur_last && core_done) begin
          core_d = C_IDLE;
        end
      end
      default: core_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fill_q      <= F_DATA;
      core_q      <= C_IDLE;
      wr_idx      <= '0;
      bit_len     <= '0;
      pad_pend    <= 1'b0;
      wait_to_pad <= 1'b0;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      buf_full    <= '0;
      buf_last    <= '0;
      cur_last    <= 1'b0;
      underrun    <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int w = 0; w < WORDS; w++) begin
          buf_word[b][w] <= '0;
        end
      end
    end else begin
      fill_q      <= fill_d;
      core_q      <= core_d;
      wr_idx      <= wr_idx_d;
      bit_len     <= bit_len_d;
      pad_pend    <= pad_pend_d;
      wait_to_pad <= wait_to_pad_d;
      wr_sel      <= wr_sel_d;
      if (word_we) buf_word[wr_sel][wr_idx] <= word_wd;
      if (len_we) begin
        buf_word[wr_sel][LEN_WORD_HI] <= len64[63:32];
        buf_word[wr_sel][LEN_WORD_LO] <= len64[31:0];
      end
      if (take_blk) begin
        buf_full[rd_sel] <= 1'b0;
        rd_sel           <= ~rd_sel;
      end
      // Set after clear: on an underrun the fill may close the very buffer being skipped.
      if (set_full) begin
        buf_full[wr_sel] <= 1'b1;
        buf_last[wr_sel] <= set_last;
      end
      if (core_start || (take_blk && core_q == C_RUN)) cur_last <= buf_last[rd_sel];
      if (core_start) underrun <= 1'b0;
      else if (underrun_set) underrun <= 1'b1;
    end
  end

  always_comb begin
    core_block = '0;
    for (int i = 0; i < WORDS; i++) begin
      core_block[SHA256_BLOCK_W-1-WORD_W*i -: WORD_W] = buf_word[rd_sel][i];
    end
  end

  assign core_last_block = cur_last;
  assign busy = !(fill_q == F_DATA && wr_idx == 4'd0) || (|buf_full) || (core_q != C_IDLE);

endmodule
`default_nettype wire
